// File: rtl/result_uart.sv
`default_nettype none
// ============================================================================
//  Module      : result_uart
//  Description : Serialises a 32-bit match counter as an ASCII hex report
//                ("XXXXXXXX\r\n") over a UART line whenever the pipeline's
//                found flag rises while the transmitter is idle.
//                Optional build macro RESULT_UART_PARITY_EN adds one even
//                parity bit per frame (8E1 instead of 8N1).
//  Revision    : 1.0 - initial release
// ============================================================================
module result_uart #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        found,
    input  logic [31:0] counter_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int                  c_DIV       = CLK_FREQ / BAUD;
    localparam int                  c_BAUD_W    = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_DIV - 1);
    localparam logic [3:0]          c_LAST_BYTE = 4'd9;
    localparam logic [2:0]          c_LAST_BIT  = 3'd7;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
`ifdef RESULT_UART_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic [2:0]          r_state;
    logic [2:0]          w_state_next;
    logic                r_found_prev;
    logic [31:0]         r_report;
    logic [3:0]          r_byte_idx;
    logic [2:0]          r_bit_idx;
    logic [c_BAUD_W-1:0] r_baud;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    logic                w_start;
    logic                w_bit_end;
    logic [3:0]          w_nibble;
    logic [7:0]          w_byte;
    logic                w_tx_next;

    // A report is only accepted on a fresh rising edge while fully idle; the
    // registered busy also covers the cycle right after IDLE is re-entered.
    assign w_start   = (r_state == S_IDLE) && !r_busy && found && !r_found_prev;
    assign w_bit_end = (r_baud == c_BAUD_LAST);

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

    // Select the current byte: eight hex digits MSB first, then CR, LF.
    always_comb begin
        w_nibble = 4'h0;
        w_byte   = 8'h00;
        case (r_byte_idx)
            4'd0:    w_nibble = r_report[31:28];
            4'd1:    w_nibble = r_report[27:24];
            4'd2:    w_nibble = r_report[23:20];
            4'd3:    w_nibble = r_report[19:16];
            4'd4:    w_nibble = r_report[15:12];
            4'd5:    w_nibble = r_report[11:8];
            4'd6:    w_nibble = r_report[7:4];
            4'd7:    w_nibble = r_report[3:0];
            default: w_nibble = 4'h0;
        endcase
        if (r_byte_idx == 4'd8) begin
            w_byte = 8'h0D;
        end else if (r_byte_idx == c_LAST_BYTE) begin
            w_byte = 8'h0A;
        end else if (w_nibble < 4'd10) begin
            w_byte = 8'h30 + {4'h0, w_nibble};
        end else begin
            w_byte = 8'h37 + {4'h0, w_nibble};
        end
    end

    // Next-state and next line level; the line is registered one cycle later.
    always_comb begin
        w_state_next = r_state;
        w_tx_next    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                w_tx_next = 1'b0;
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_tx_next = w_byte[r_bit_idx];
                if (w_bit_end && (r_bit_idx == c_LAST_BIT)) begin
`ifdef RESULT_UART_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef RESULT_UART_PARITY_EN
            S_PARITY: begin
                w_tx_next = ^w_byte;
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_state_next = (r_byte_idx == c_LAST_BYTE) ? S_IDLE : S_START;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: edge detect, report capture, baud/bit/byte counters, outputs.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_found_prev <= 1'b0;
            r_report     <= 32'h0;
            r_byte_idx   <= 4'd0;
            r_bit_idx    <= 3'd0;
            r_baud       <= '0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_found_prev <= found;
            r_tx         <= w_tx_next;
            r_busy       <= (r_state != S_IDLE);
            r_done       <= (r_state == S_NEXT) && (r_byte_idx == c_LAST_BYTE);

            if (w_start) begin
                r_report <= counter_in;
            end

            // Baud counter restarts at every bit boundary and between bytes.
            if ((r_state == S_IDLE) || (r_state == S_NEXT) || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            if (r_state == S_DATA) begin
                if (w_bit_end) begin
                    r_bit_idx <= r_bit_idx + 3'd1;
                end
            end else begin
                r_bit_idx <= 3'd0;
            end

            if (r_state == S_NEXT) begin
                r_byte_idx <= (r_byte_idx == c_LAST_BYTE) ? 4'd0 : (r_byte_idx + 4'd1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_result_uart.sv
`default_nettype none
// ============================================================================
//  Module      : tb_result_uart
//  Description : Self-checking bench for result_uart. Records the serial line
//                during each report, decodes it with a mid-bit sampling
//                receiver and compares against the hex text of the value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_result_uart;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
`ifdef RESULT_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int REPORT_CYC = 10 * FB * DIV + 10;

    logic        CLK        = 1'b0;
    logic        reset      = 1'b0;
    logic        found      = 1'b0;
    logic [31:0] counter_in = 32'h0;
    logic        tx;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic       txq[$];
    logic [7:0] rx[$];
    logic       rxp[$];
    int         busy_cyc;
    int         done_cnt;
    int         ferr;

    result_uart #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .found     (found),
        .counter_in(counter_in),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected report text: hex digits of v, MSB first, then CR LF.
    function automatic logic [7:0] exp_byte(input logic [31:0] v, input int k);
        string      hexs;
        logic [3:0] n;
        hexs = "0123456789ABCDEF";
        if (k == 8) return 8'h0D;
        if (k == 9) return 8'h0A;
        n = 4'(v >> (28 - 4 * k));
        return hexs[int'(n)];
    endfunction

    // Generic UART receiver over the recorded line samples.
    task automatic decode();
        int         i;
        int         m;
        logic [7:0] b;
        rx.delete();
        rxp.delete();
        ferr = 0;
        i    = 0;
        while (i < txq.size()) begin
            if (txq[i] === 1'b0) begin
                m = i + DIV / 2;
                if (m + (FB - 1) * DIV >= txq.size()) begin
                    ferr++;
                    i = txq.size();
                end else begin
                    if (txq[m] !== 1'b0) ferr++;
                    for (int j = 0; j < 8; j++) b[j] = txq[m + (j + 1) * DIV];
                    rx.push_back(b);
`ifdef RESULT_UART_PARITY_EN
                    rxp.push_back(txq[m + 9 * DIV]);
                    if (txq[m + 9 * DIV] !== ^b) ferr++;
`endif
                    if (txq[m + (FB - 1) * DIV] !== 1'b1) ferr++;
                    i = m + (FB - 1) * DIV + 1;
                end
            end else begin
                i++;
            end
        end
    endtask

    // Line must stay idle with no activity for n cycles.
    task automatic quiet(input int n);
        int bad;
        bad = 0;
        for (int c = 0; c < n; c++) begin
            if (busy !== 1'b0 || tx !== 1'b1 || done !== 1'b0) bad++;
            tick();
        end
        chk("quiet_idle", bad, 0);
    endtask

    // mode 0: found dropped early; 1: glitch during byte 3 and new counter;
    // 2: found held high; 3: found raised again in the done cycle.
    task automatic do_report(input logic [31:0] v, input int mode);
        int          cyc;
        int          b3;
        logic [31:0] obs;
        counter_in = v;
        found      = 1'b1;
        b3         = 3 * (FB * DIV + 1);
        tick();
        chk("capture_busy", busy, 0);
        chk("capture_tx", tx, 1);
        tick();
        chk("latency_busy", busy, 1);
        chk("latency_tx", tx, 0);
        txq.delete();
        busy_cyc = 0;
        done_cnt = 0;
        cyc      = 0;
        while (busy === 1'b1 && cyc < 3 * REPORT_CYC) begin
            txq.push_back(tx);
            busy_cyc++;
            if (done === 1'b1) begin
                done_cnt++;
                if (mode == 3) found = 1'b1;
            end
            cyc++;
            if (cyc == 20 && (mode == 0 || mode == 3)) found = 1'b0;
            if (mode == 1) begin
                if (cyc == b3 + 20) found = 1'b0;
                if (cyc == b3 + 30) found = 1'b1;
                if (cyc == b3 + 40) found = 1'b0;
                if (cyc == b3 + 50) begin
                    found      = 1'b1;
                    counter_in = ~v;
                end
            end
            tick();
        end
        chk("busy_cycles", busy_cyc, REPORT_CYC);
        chk("done_pulses", done_cnt, 1);
        decode();
        chk("frame_errors", ferr, 0);
        chk("byte_count", rx.size(), 10);
        for (int k = 0; k < 10; k++) begin
            obs = (k < rx.size()) ? {24'h0, rx[k]} : 32'hFFFF_FFFF;
            chk($sformatf("byte%0d_of_%08h", k, v), obs, {24'h0, exp_byte(v, k)});
        end
        quiet(60);
    endtask

    initial begin
        logic [31:0] rv;

        reset = 1'b0;
        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_busy", busy, 0);

        do_report(32'h1234ABCD, 0);
        do_report(32'h00000000, 0);
        do_report(32'hFFFFFFFF, 0);
        repeat (3) do_report($urandom(), 0);

        // Re-trigger attempts during byte 3 are ignored.
        do_report($urandom(), 1);
        found = 1'b0;
        tick();

        // Edge presented while busy is still high at the end of a report.
        do_report($urandom(), 3);
        found = 1'b0;
        tick();

        // One-cycle reset at cycle 250 of a report aborts it.
        rv         = $urandom();
        counter_in = rv;
        found      = 1'b1;
        tick();
        tick();
        for (int c = 1; c < 250; c++) begin
            if (c == 20) found = 1'b0;
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_tx", tx, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        quiet(300);
        do_report($urandom(), 0);

        // found held high across reset release: one report only.
        reset      = 1'b0;
        found      = 1'b1;
        repeat (3) tick();
        reset = 1'b1;
        do_report($urandom(), 2);

`ifdef RESULT_UART_PARITY_EN
        found = 1'b0;
        tick();
        do_report(32'h00000007, 0);
        chk("parity_count", rxp.size(), 10);
        if (rxp.size() == 10) begin
            chk("parity_char0", rxp[0], 0);
            chk("parity_char7", rxp[7], 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
